// File: rtl/ram8_pkg.sv
// Shared constants and types for the ram8 memory tile.
// Also holds the one-hot address decoder used to steer the write enable.
package ram8_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  function automatic logic [DEPTH-1:0] decodeOneHot(input addr_t a);
    logic [DEPTH-1:0] sel;
    sel    = '0;
    sel[a] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/ram8_word.sv
// One storage word of ram8: a DATA_W register with synchronous clear and load enable.
module ram8_word
  import ram8_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) data_d = in;
  end

  // Clear wins over load, so a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign out = data_q;

endmodule

// File: rtl/ram8.sv
// Eight-word RAM tile: clocked write port, combinational read port, one shared address.
// Optional RAM8_WRITE_BYPASS_EN forwards pending write data straight to out.
module ram8
  import ram8_pkg::*;
#(
  parameter int DATA_W = ram8_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] val,
  input  logic              load,
  input  logic [2:0]        address,
  output logic [DATA_W-1:0] out
);

  logic [DEPTH-1:0]  loadSel;
  logic [DATA_W-1:0] wordOut [DEPTH];
  logic [DATA_W-1:0] storedOut;

  always_comb begin
    loadSel = '0;
    if (load) loadSel = decodeOneHot(addr_t'(address));
  end

  for (genvar g = 0; g < DEPTH; g++) begin : gWord
    ram8_word #(
      .W(DATA_W)
    ) uWord (
      .clk (clk),
      .rst (rst),
      .load(loadSel[g]),
      .in  (val),
      .out (wordOut[g])
    );
  end

  assign storedOut = wordOut[address];

`ifdef RAM8_WRITE_BYPASS_EN
  // A write about to land is shown on the read port before the edge.
  always_comb begin
    out = storedOut;
    if (load && !rst) out = val;
  end
`else
  always_comb begin
    out = storedOut;
  end
`endif

endmodule

// File: tb/tb_ram8.sv
// Self-checking bench for ram8: directed vectors feed a scoreboard queue,
// and a separate monitor pops each expectation and compares it against out.
module tb_ram8;

  logic        clk;
  logic        rst;
  logic [15:0] val;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } expect_t;

  expect_t expQ[$];
  event    sampleEv;
  int      checkCount = 0;
  int      passCount  = 0;

  ram8 #(
    .DATA_W(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .val    (val),
    .load   (load),
    .address(address),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: each sample request drains the queue against the live output.
  initial begin
    forever begin
      @(sampleEv);
      #1;
      while (expQ.size() > 0) begin
        expect_t e;
        e = expQ.pop_front();
        checkCount++;
        if (out === e.exp) passCount++;
        else $display("[TB] FAIL %s: out=%h expected=%h", e.name, out, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic l, input logic [2:0] a,
                               input logic [15:0] v);
    rst     = r;
    load    = l;
    address = a;
    val     = v;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] exp);
    expect_t e;
    e.name = name;
    e.exp  = exp;
    expQ.push_back(e);
    -> sampleEv;
    #2;
  endtask

  logic [15:0] twoWrites [8];
  logic [15:0] bypassExp;
  int          waitCycles;

  initial begin
    twoWrites = '{16'h0000, 16'h0000, 16'h0000, 16'h0003,
                  16'h0000, 16'h000F, 16'h0000, 16'h0000};
`ifdef RAM8_WRITE_BYPASS_EN
    bypassExp = 16'h00AA;
`else
    bypassExp = 16'h0000;
`endif

    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      checkOutput($sformatf("reset_addr%0d", i), 16'h0000);
    end

    tick();
    applyStimulus(1'b0, 1'b1, 3'd3, 16'h0003);
    tick();
    applyStimulus(1'b0, 1'b1, 3'd5, 16'h000F);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      checkOutput($sformatf("write_addr%0d", i), twoWrites[i]);
    end

    tick();
    applyStimulus(1'b0, 1'b0, 3'd3, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("hold_edge%0d", i), 16'h0003);
    end

    applyStimulus(1'b1, 1'b1, 3'd5, 16'hABCD);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd5, 16'h0000);
    checkOutput("rstprio_addr5", 16'h0000);
    address = 3'd3;
    checkOutput("rstprio_addr3", 16'h0000);

    tick();
    applyStimulus(1'b0, 1'b1, 3'd7, 16'h1234);
    tick();
    checkOutput("overwrite_first", 16'h1234);
    val = 16'h5678;
`ifdef RAM8_WRITE_BYPASS_EN
    checkOutput("overwrite_pending", 16'h5678);
`else
    checkOutput("overwrite_pending", 16'h1234);
`endif
    tick();
    load = 1'b0;
    checkOutput("async_addr7a", 16'h5678);
    address = 3'd0;
    checkOutput("async_addr0", 16'h0000);
    address = 3'd7;
    checkOutput("async_addr7b", 16'h5678);

    tick();
    applyStimulus(1'b0, 1'b1, 3'd2, 16'h00AA);
    checkOutput("bypass_pre_edge", bypassExp);
    tick();
    load = 1'b0;
    checkOutput("bypass_post_edge", 16'h00AA);
    address = 3'd7;
    checkOutput("retain_addr7", 16'h5678);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 100) begin
      tick();
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      checkCount += expQ.size();
      $display("[TB] FAIL drain: pending=%0d expected=0", expQ.size());
      expQ.delete();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
